// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit feeding the HI/LO register pair
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs, q_s, r_s, q_u, r_u;
  // Divisor forced to 1 on divide-by-zero (result discarded anyway) and on
  // 0x80000000 / -1, where dividing by 1 yields the wrapped quotient and zero remainder.
  assign dvs    = (B == 32'd0 || (A == 32'h8000_0000 && B == 32'hffff_ffff)) ? 32'd1 : B;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign q_s    = $signed(A) / $signed(dvs);
  assign r_s    = $signed(A) % $signed(dvs);
  assign q_u    = A / dvs;
  assign r_u    = A % dvs;
  assign Busy   = state_q == RUN;
  assign HI     = hi_q;
  assign LO     = lo_q;
  // Next-state: launch ops from IDLE, count down in RUN and commit on the last busy cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (state_q == IDLE && Start) begin
      if (!MDOp[2]) begin
        state_d = RUN;
        cnt_d   = MDOp[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        {hi_tmp_d, lo_tmp_d} = (MDOp[1] && B == 32'd0) ? {hi_q, lo_q} :
                               MDOp == 3'd0 ? prod_s :
                               MDOp == 3'd1 ? prod_u :
                               MDOp == 3'd2 ? {r_s, q_s} : {r_u, q_u};
      end else begin
        hi_d = MDOp == 3'd4 ? A : hi_q;
        lo_d = MDOp == 3'd5 ? A : lo_q;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        hi_d    = hi_tmp_q;
        lo_d    = lo_tmp_q;
      end
    end
  end
  // State registers with synchronous reset that also aborts any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd7;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;
  int vectors = 0;
  int errs = 0;
  logic [63:0] sb[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mthi/mtlo/no-op: single-cycle, never raises Busy
  task automatic mt(input logic [2:0] op, input logic [31:0] a, input logic [31:0] eh, input logic [31:0] el);
    Start = 1'b1; MDOp = op; A = a; B = 32'hdead_beef;
    @(negedge clk);
    Start = 1'b0;
    chk("mt_busy", {31'd0, Busy}, 32'd0);
    chk("mt_hi", HI, eh);
    chk("mt_lo", LO, el);
  endtask

  // Launch a multi-cycle op; optionally pulse Start in busy cycles p1 (mthi) / p2 (mult)
  // and assert reset in busy cycle rc. HI/LO must hold their prior values while busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                       input int p1, input int p2, input int rc);
    logic [31:0] pre_hi, pre_lo;
    logic [63:0] exp;
    int n;
    pre_hi = HI; pre_lo = LO;
    Start = 1'b1; MDOp = op; A = a; B = b;
    sb.push_back({eh, el});
    @(negedge clk);
    Start = 1'b0; A = 32'h5a5a_5a5a; B = 32'h0;
    n = 0;
    while (Busy && n < 40) begin
      chk("hold_hi", HI, pre_hi);
      chk("hold_lo", LO, pre_lo);
      n++;
      Start = (n == p1) || (n == p2);
      MDOp  = (n == p1) ? 3'd4 : 3'd0;
      A     = 32'h1234;
      B     = 32'd5;
      reset = (n == rc);
      @(negedge clk);
    end
    Start = 1'b0; reset = 1'b0;
    chk("busy_len", n, ecyc);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      chk("res_hi", HI, exp[63:32]);
      chk("res_lo", LO, exp[31:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    issue(3'd0, 32'hffff_fffe, 32'd3, 32'hffff_ffff, 32'hffff_fffa, 5, 0, 0, 0);
    issue(3'd1, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 5, 0, 0, 0);
    issue(3'd2, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 10, 0, 0, 0);
    issue(3'd3, 32'hffff_fff9, 32'd2, 32'h0000_0001, 32'h7fff_fffc, 10, 0, 0, 0);
    issue(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, 10, 0);
    mt(3'd5, 32'habcd, 32'd2, 32'habcd);
    mt(3'd4, 32'h11, 32'h11, 32'habcd);
    mt(3'd5, 32'h22, 32'h11, 32'h22);
    mt(3'd6, 32'h99, 32'h11, 32'h22);
    issue(3'd3, 32'h1234, 32'd0, 32'h11, 32'h22, 10, 0, 0, 0);
    issue(3'd2, 32'h1234, 32'd0, 32'h11, 32'h22, 10, 0, 0, 0);
    issue(3'd0, 32'd5, 32'd6, 32'd0, 32'd0, 3, 0, 0, 3);
    for (int i = 0; i < 8; i++) begin
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      @(negedge clk);
    end
    issue(3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 5, 0, 0, 0);
    issue(3'd2, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 10, 0, 0, 0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5, 0, 0, 0);
    issue(3'd2, 32'd7, 32'hffff_fffe, 32'd1, 32'hffff_fffd, 10, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that sits beside the ALU in the EX stage.
- Executes mult, multu, div and divu into the HI/LO register pair.
- Services mthi/mtlo writes and exposes HI/LO for mfhi/mflo readback.
- Raises Busy so the hazard unit stalls any later MD instruction until the result commits.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request strobe; MDOp, A and B are sampled on the same edge
- MDOp  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- Busy  output  1  high while an operation is in flight
- HI  output  32  HI register (product high word / remainder)
- LO  output  32  LO register (product low word / quotient)

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high and is evaluated before all other conditions.
- Reset values: HI=0, LO=0, Busy=0, cycle counter=0, FSM=IDLE.
- FSM states: IDLE and RUN.
- IDLE, Start=1, MDOp 0..3:
  - Compute the 64-bit result from A and B into internal HI_tmp/LO_tmp.
  - Load counter with MULT_CYCLES (ops 0, 1) or DIV_CYCLES (ops 2, 3).
  - Go to RUN.
  - HI/LO are unchanged at this edge.
- IDLE, Start=1, MDOp 4: HI<=A at that edge. MDOp 5: LO<=A at that edge. No Busy, stay IDLE.
- IDLE, Start=1, MDOp 6/7: no effect.
- RUN: decrement counter each edge. On the edge where counter==1:
  - HI<=HI_tmp, LO<=LO_tmp.
  - counter<=0, go to IDLE.
- Busy is a registered output and equals (state==RUN). It is high for exactly N consecutive cycles, starting the cycle after the Start edge. New HI/LO are visible in the first cycle Busy is low.
- Start while Busy=1, any MDOp (including mthi/mtlo): ignored, with no effect on HI/LO or counter. This includes the last busy cycle.
- Arithmetic:
  - mult: signed 32x32 to 64; {HI,LO}=$signed(A)*$signed(B).
  - multu: unsigned 32x32 to 64.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Special cases:
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - B==0 for div/divu: the operation still runs DIV_CYCLES with Busy, but HI and LO keep their prior values at the commit edge.
- Reset mid-operation: aborts the operation, discards the pending result and applies the reset values above at that edge.
- No other path modifies HI/LO. Operands do not need to be held stable after the Start edge.

Test Plan:
- Reset, then check outputs; Start=1, MDOp=0, A=0xFFFFFFFE (-2), B=3:
  - Busy=1 for exactly 5 cycles.
  - HI=0xFFFFFFFF and LO=0xFFFFFFFA in the first cycle Busy=0.
  - HI/LO stay 0 during Busy.
- MDOp=1, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- MDOp=2, A=-7 (0xFFFFFFF9), B=2:
  - Busy for 10 cycles.
  - LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Then MDOp=3, A=0xFFFFFFF9, B=2 -> LO=0x7FFFFFFC, HI=1.
- Issue div A=100, B=7; in busy cycles 3 and 10, pulse Start with MDOp=4, A=0x1234 and MDOp=0:
  - Both pulses are ignored.
  - Final HI=2, LO=14, Busy length is 10.
  - After Busy drops, MDOp=5, A=0xABCD gives LO=0xABCD next cycle with Busy still 0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo; divu with B=0 -> Busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Start mult A=5, B=6; assert reset in busy cycle 3:
  - Next cycle Busy=0, HI=0, LO=0.
  - No commit ever appears.
  - A fresh mult 5x6 afterwards yields LO=30, HI=0 after 5 cycles.
